// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK-cell modulo counter.
//   jk_cmd_e      : decoded per-edge command (clr > load > en > hold)
//   JK_HOLD       : J/K pair that leaves a cell unchanged
//   jk_from_next  : J/K pair that moves one cell from q to nxt
package jk_pkg;

  typedef enum logic [1:0] {
    CMD_HOLD = 2'd0,
    CMD_CNT  = 2'd1,
    CMD_LOAD = 2'd2,
    CMD_CLR  = 2'd3
  } jk_cmd_e;

  localparam logic [1:0] JK_HOLD = 2'b00;

  // Returns {J, K}. Set-only or reset-only drive, so J=K=1 never occurs.
  function automatic logic [1:0] jk_from_next(input logic q, input logic nxt);
    return {nxt & ~q, ~nxt & q};
  endfunction

endpackage

// File: rtl/jk_mod_counter_jkff_n.sv
// Single-bit JK flip-flop with asynchronous active-low reset.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-low reset, forces q to 0
//   j   : set request
//   k   : reset request
//   q   : stored bit
module jkff_n
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK cell: hold, reset, set, toggle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD: q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter whose state lives in WIDTH JK cells.
// A target value is computed each cycle and converted to per-bit J/K drive.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset (q, wrap, ovf -> 0)
//   en    : count enable
//   up    : 1 = increment, 0 = decrement
//   load  : synchronous load of d (range-limited to 0..MOD-1)
//   clr   : synchronous clear of count and ovf
//   d     : load value
//   q     : current count (JK cell outputs)
//   tc    : combinational terminal count for the active direction
//   wrap  : registered one-cycle pulse, previous edge wrapped
//   ovf   : sticky wrap flag, cleared by clr or reset
//   j_dbg : combinational J vector applied to the cells
//   k_dbg : combinational K vector applied to the cells
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned MOD        = 16,
  parameter bit          LOAD_CLAMP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf,
  output logic [WIDTH-1:0] j_dbg,
  output logic [WIDTH-1:0] k_dbg
);

  // One guard bit so +1 at MOD-1 and MOD itself are representable.
  localparam int unsigned EW = WIDTH + 1;

  // Reject parameter sets the counter cannot represent.
  if (WIDTH < 2) begin : g_bad_width
    $error("jk_mod_counter: WIDTH must be >= 2");
  end
  if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
    $error("jk_mod_counter: MOD must be in 2..2**WIDTH");
  end

  localparam logic [EW-1:0] MOD_EXT  = EW'(MOD);
  localparam logic [EW-1:0] LAST_EXT = EW'(MOD - 1);

  jk_cmd_e          cmd;
  logic [EW-1:0]    q_ext;
  logic [EW-1:0]    d_ext;
  logic [WIDTH-1:0] nxt;
  logic             wrap_nxt;
  logic             ovf_nxt;
  logic             at_last;
  logic             at_zero;

  assign q_ext   = {1'b0, q};
  assign d_ext   = {1'b0, d};
  assign at_last = (q_ext == LAST_EXT);
  assign at_zero = (q_ext == '0);

  // Priority decode of the control inputs.
  always_comb begin
    cmd = CMD_HOLD;
    if (clr) begin
      cmd = CMD_CLR;
    end else if (load) begin
      cmd = CMD_LOAD;
    end else if (en) begin
      cmd = CMD_CNT;
    end
  end

  // Target count plus the wrap/ovf values to register on this edge.
  always_comb begin
    nxt      = q;
    wrap_nxt = 1'b0;
    ovf_nxt  = ovf;
    case (cmd)
      CMD_CLR: begin
        nxt     = '0;
        ovf_nxt = 1'b0;
      end
      CMD_LOAD: begin
        if (d_ext < MOD_EXT) begin
          nxt = d;
        end else if (LOAD_CLAMP) begin
          nxt = WIDTH'(LAST_EXT);
        end else begin
          nxt = WIDTH'(d_ext % MOD_EXT);
        end
      end
      CMD_CNT: begin
        if (up) begin
          if (at_last) begin
            nxt      = '0;
            wrap_nxt = 1'b1;
          end else begin
            nxt = WIDTH'(q_ext + EW'(1));
          end
        end else begin
          if (at_zero) begin
            nxt      = WIDTH'(LAST_EXT);
            wrap_nxt = 1'b1;
          end else begin
            nxt = WIDTH'(q_ext - EW'(1));
          end
        end
        if (wrap_nxt) begin
          ovf_nxt = 1'b1;
        end
      end
      default: begin
        nxt = q;
      end
    endcase
  end

  // Terminal count: the next enabled edge would wrap.
  assign tc = en & ~load & ~clr & ((up & at_last) | (~up & at_zero));

  // Per-bit JK drive and storage cells.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic [1:0] jk;
    assign jk       = jk_from_next(q[i], nxt[i]);
    assign j_dbg[i] = jk[1];
    assign k_dbg[i] = jk[0];

    jkff_n u_cell (
      .clk (clk),
      .rst (rst),
      .j   (jk[1]),
      .k   (jk[0]),
      .q   (q[i])
    );
  end

  // Wrap pulse and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      wrap <= wrap_nxt;
      ovf  <= ovf_nxt;
    end
  end

endmodule
